rom_loader: RTL

- Boot-time program loader sitting directly upstream of the 32K instruction ROM.
- Receives a framed byte stream over a valid/ready handshake from the serial receiver and assembles big-endian 16-bit instructions.
- Writes each instruction into the ROM through the ROM's address/data/load port.
- Holds the CPU in reset until the complete image has arrived and its checksum matches.

---
 rtl/rom_loader.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/rom_loader.sv
// Boot-time program loader: receives a framed byte stream, writes big-endian
// 16-bit words into the instruction ROM and releases the CPU once the image checks out.
module rom_loader #(
    parameter int ADDR_W   = 15,
    parameter int TIMEOUT  = 1000000,
    parameter bit CHECK_EN = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic [ADDR_W-1:0] rom_adr,
    output logic [15:0]       rom_d,
    output logic              rom_load,
    output logic              cpu_reset,
    output logic              busy,
    output logic              done,
    output logic              error
);

    // Byte handshake: a byte moves on a rising edge where rx_valid & rx_ready;
    // rx_data must be stable while rx_valid is high and rx_ready is low.
    typedef enum logic [3:0] {
        S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA_HI, S_DATA_LO,
        S_WRITE, S_CHK, S_DONE, S_ERROR
    } state_t;

    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    state_t            state, state_next;
    logic [15:0]       len;
    logic [15:0]       len_in;
    logic [ADDR_W:0]   idx;
    logic [31:0]       idx_inc;
    logic [7:0]        data_hi;
    logic [7:0]        chk_acc;
    logic [TW-1:0]     idle_cnt;
    logic              accept;
    logic              go;
    logic              timeout_hit;
    logic              too_long;

    function automatic logic in_frame(input state_t s);
        return (s == S_LEN_HI) || (s == S_LEN_LO) || (s == S_DATA_HI) ||
               (s == S_DATA_LO) || (s == S_WRITE) || (s == S_CHK);
    endfunction

    assign accept   = rx_valid & rx_ready;
    assign go       = start && ((state == S_IDLE) || (state == S_DONE) || (state == S_ERROR));
    assign len_in   = {len[15:8], rx_data};
    assign idx_inc  = 32'(idx) + 32'd1;
    assign too_long = 32'(len_in) > (32'd1 << ADDR_W);
    // Fires on the edge that ends the TIMEOUT-th consecutive idle cycle.
    assign timeout_hit = (TIMEOUT != 0) && in_frame(state) && !accept &&
                         (idle_cnt == TW'(TIMEOUT - 1));

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE, S_DONE, S_ERROR: if (start) state_next = S_LEN_HI;
            S_LEN_HI:  if (accept) state_next = S_LEN_LO;
            S_LEN_LO: begin
                if (accept) begin
                    if (len_in == 16'd0) state_next = S_CHK;
                    else if (too_long)   state_next = S_ERROR;
                    else                 state_next = S_DATA_HI;
                end
            end
            S_DATA_HI: if (accept) state_next = S_DATA_LO;
            S_DATA_LO: if (accept) state_next = S_WRITE;
            S_WRITE:   state_next = (idx_inc == 32'(len)) ? S_CHK : S_DATA_HI;
            S_CHK: begin
                if (accept)
                    state_next = (!CHECK_EN || (chk_acc == rx_data)) ? S_DONE : S_ERROR;
            end
            default: state_next = S_IDLE;
        endcase
        if (timeout_hit) state_next = S_ERROR;
    end

    // Output decode
    always_comb begin
        rx_ready = 1'b0;
        rom_load = 1'b0;
        case (state)
            S_LEN_HI, S_LEN_LO, S_DATA_HI, S_DATA_LO, S_CHK: rx_ready = 1'b1;
            S_WRITE: rom_load = 1'b1;
            default: ;
        endcase
    end

    // Datapath and registered status outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            len       <= '0;
            idx       <= '0;
            data_hi   <= '0;
            chk_acc   <= '0;
            idle_cnt  <= '0;
            rom_adr   <= '0;
            rom_d     <= '0;
            cpu_reset <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
        end else begin
            cpu_reset <= (state_next != S_DONE);
            done      <= (state_next == S_DONE);
            error     <= (state_next == S_ERROR);
            busy      <= in_frame(state_next);

            if (go || accept)        idle_cnt <= '0;
            else if (in_frame(state)) idle_cnt <= idle_cnt + 1'b1;

            if (go) begin
                idx     <= '0;
                chk_acc <= '0;
            end

            if (accept) begin
                case (state)
                    S_LEN_HI: len[15:8] <= rx_data;
                    S_LEN_LO: len[7:0]  <= rx_data;
                    S_DATA_HI: begin
                        data_hi <= rx_data;
                        chk_acc <= chk_acc ^ rx_data;
                    end
                    S_DATA_LO: begin
                        rom_adr <= idx[ADDR_W-1:0];
                        rom_d   <= {data_hi, rx_data};
                        chk_acc <= chk_acc ^ rx_data;
                    end
                    default: ;
                endcase
            end

            if (state == S_WRITE) idx <= idx + 1'b1;
        end
    end

endmodule
